fpa_issue_ctrl: RTL and testbench

- Operand-issue and result-capture stage wrapped around the 8-bit floating-point adder core (FPA_Top).
- Buffers incoming operand pairs in a small FIFO and drives the adder's a/b/start inputs, one operation at a time.
- Samples ans/ans_except a fixed latency after issue and presents each result on a valid/ready output port.
- Turns the adder's start-pulse interface into a streaming interface for upstream and downstream logic.

---
 rtl/fpa_pkg.sv | 29 ++
 rtl/fpa_op_fifo.sv | 70 +++++++
 rtl/fpa_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fpa_issue_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared definitions for the FP8 adder issue/capture stage: number format
// widths, operand-pair width and the issue FSM state encoding.
`timescale 1ns/1ps
package fpa_pkg;

    // FP8 layout: 1 sign bit, 4 exponent bits, 3 mantissa bits
    localparam int EXP_W = 4;
    localparam int MAN_W = 3;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int EXC_W = 4;

    // One queued operation is the pair {a, b}
    localparam int OP_W  = 2 * FP_W;

    // Issue sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fsm_state_t;

    // Pack an operand pair into one FIFO word, A in the upper half
    function automatic logic [OP_W-1:0] pack_ops(input logic [FP_W-1:0] a,
                                                 input logic [FP_W-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/fpa_op_fifo.sv
// Operand-pair FIFO: DEPTH entries (power of two), synchronous push/pop,
// head visible combinationally, occupancy count plus full/empty flags.
// A push while full or a pop while empty is ignored.
`timescale 1ns/1ps
module fpa_op_fifo
    import fpa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OP_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array: write the tail entry on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers (wrap naturally at DEPTH) and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fpa_issue_ctrl.sv
// Issue/capture stage around the FP8 adder core. Operand pairs are queued,
// issued one at a time with a START_W-cycle start pulse, and the adder result
// is sampled FPA_LAT cycles after the issue edge and held on a valid/ready
// output until consumed. Compile with FPA_ISSUE_STATS_EN defined to add the
// stat_ops / stat_exc handshake counters.
`timescale 1ns/1ps
module fpa_issue_ctrl
    import fpa_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int START_W = 2,
    parameter int FPA_LAT = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_a,
    input  logic [FP_W-1:0]   in_b,
    output logic [FP_W-1:0]   fpa_a,
    output logic [FP_W-1:0]   fpa_b,
    output logic              fpa_start,
    input  logic [FP_W-1:0]   fpa_ans,
    input  logic [EXC_W-1:0]  fpa_except,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_ans,
    output logic [EXC_W-1:0]  out_except
`ifdef FPA_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_exc
`endif
);

    localparam int CNT_W  = $clog2(FPA_LAT + 1);
    localparam int QCNT_W = $clog2(DEPTH + 1);

    fsm_state_t         state_r;
    fsm_state_t         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [FP_W-1:0]    a_r;
    logic [FP_W-1:0]    a_nxt_s;
    logic [FP_W-1:0]    b_r;
    logic [FP_W-1:0]    b_nxt_s;
    logic [FP_W-1:0]    ans_r;
    logic [FP_W-1:0]    ans_nxt_s;
    logic [EXC_W-1:0]   exc_r;
    logic [EXC_W-1:0]   exc_nxt_s;
    logic               start_r;
    logic               start_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               in_ready_r;

    logic               push_s;
    logic               pop_s;
    logic               handshake_s;
    logic               start_done_s;
    logic               capture_s;
    logic [OP_W-1:0]    head_s;
    logic [QCNT_W-1:0]  q_count_s;
    logic [QCNT_W-1:0]  q_count_nxt_s;
    logic               q_full_s;
    logic               q_empty_s;

    // in_ready is a register, so a full FIFO refuses pushes even when the
    // sequencer pops in the same cycle.
    assign push_s       = in_valid & in_ready_r & ~q_full_s;
    assign pop_s        = (state_r == IDLE) & ~q_empty_s;
    assign handshake_s  = (state_r == HOLD) & valid_r & out_ready;
    // cnt_r holds the number of edges since the pop edge
    assign start_done_s = (cnt_r == CNT_W'(START_W - 1));
    assign capture_s    = (cnt_r == CNT_W'(FPA_LAT - 1));

    fpa_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (clr),
        .push      (push_s),
        .push_data (pack_ops(in_a, in_b)),
        .pop       (pop_s),
        .head      (head_s),
        .count     (q_count_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // Occupancy after this edge, used to register in_ready without lag
    always_comb begin
        q_count_nxt_s = q_count_s;
        case ({push_s, pop_s})
            2'b10:   q_count_nxt_s = q_count_s + QCNT_W'(1);
            2'b01:   q_count_nxt_s = q_count_s - QCNT_W'(1);
            default: q_count_nxt_s = q_count_s;
        endcase
    end

    // in_ready register: low in reset, then tracks free space
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (q_count_nxt_s < QCNT_W'(DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (start_done_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (capture_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: next values of every registered output
    always_comb begin
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        start_nxt_s = start_r;
        cnt_nxt_s   = cnt_r;
        valid_nxt_s = valid_r;
        ans_nxt_s   = ans_r;
        exc_nxt_s   = exc_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    a_nxt_s     = head_s[OP_W-1:FP_W];
                    b_nxt_s     = head_s[FP_W-1:0];
                    start_nxt_s = 1'b1;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    start_nxt_s = 1'b0;
                end
            end
            ISSUE: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (start_done_s) begin
                    start_nxt_s = 1'b0;
                end else begin
                    start_nxt_s = 1'b1;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (capture_s) begin
                    ans_nxt_s   = fpa_ans;
                    exc_nxt_s   = fpa_except;
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                start_nxt_s = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_r     <= {FP_W{1'b0}};
            b_r     <= {FP_W{1'b0}};
            start_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            ans_r   <= {FP_W{1'b0}};
            exc_r   <= {EXC_W{1'b0}};
        end else begin
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            start_r <= start_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= valid_nxt_s;
            ans_r   <= ans_nxt_s;
            exc_r   <= exc_nxt_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign fpa_a      = a_r;
    assign fpa_b      = b_r;
    assign fpa_start  = start_r;
    assign out_valid  = valid_r;
    assign out_ans    = ans_r;
    assign out_except = exc_r;

`ifdef FPA_ISSUE_STATS_EN
    logic [15:0] stat_ops_r;
    logic [15:0] stat_exc_r;

    // Saturating counters of completed output handshakes
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stat_ops_r <= 16'h0000;
            stat_exc_r <= 16'h0000;
        end else if (handshake_s) begin
            if (stat_ops_r != 16'hFFFF) begin
                stat_ops_r <= stat_ops_r + 16'h0001;
            end
            if ((exc_r != {EXC_W{1'b0}}) && (stat_exc_r != 16'hFFFF)) begin
                stat_exc_r <= stat_exc_r + 16'h0001;
            end
        end
    end

    assign stat_ops = stat_ops_r;
    assign stat_exc = stat_exc_r;
`endif

endmodule

// File: tb/tb_fpa_issue_ctrl.sv
// Randomized self-checking bench for fpa_issue_ctrl. A behavioural adder
// presents its result only on the cycle that is FPA_LAT cycles after the start
// edge. A queue-based reference model predicts result order and values, issue
// timing, start width, latency and in_ready.
`timescale 1ns/1ps
module tb_fpa_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int START_W = 2;
    localparam int FPA_LAT = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [7:0] fpa_a;
    logic [7:0] fpa_b;
    logic       fpa_start;
    logic [7:0] fpa_ans;
    logic [3:0] fpa_except;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_ans;
    logic [3:0] out_except;
`ifdef FPA_ISSUE_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_exc;
    int          m_ops;
    int          m_exc;
`endif

    fpa_issue_ctrl #(.DEPTH(DEPTH), .START_W(START_W), .FPA_LAT(FPA_LAT)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .fpa_a      (fpa_a),
        .fpa_b      (fpa_b),
        .fpa_start  (fpa_start),
        .fpa_ans    (fpa_ans),
        .fpa_except (fpa_except),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ans    (out_ans),
        .out_except (out_except)
`ifdef FPA_ISSUE_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_exc   (stat_exc)
`endif
    );

    always #5 clk = ~clk;

    // Adder behaviour: a ^ b ^ DE, exception bit 2 when A's exponent is all ones,
    // bit 0 when B's mantissa is all ones.
    function automatic logic [7:0] ans_fn(input logic [7:0] a, input logic [7:0] b);
        return a ^ b ^ 8'hDE;
    endfunction

    function automatic logic [3:0] exc_fn(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, (a[6:3] == 4'hF), 1'b0, (b[2:0] == 3'b111)};
    endfunction

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Adder model: result valid only FPA_LAT cycles after the start edge
    int         m_age = 0;
    logic       m_prev = 1'b0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    always @(negedge clk) begin
        m_prev <= fpa_start;
        if (fpa_start && !m_prev) begin
            m_age <= 1;
            m_a   <= fpa_a;
            m_b   <= fpa_b;
        end else if (m_age != 0 && m_age < 100) begin
            m_age <= m_age + 1;
        end
    end

    assign fpa_ans    = (m_age == FPA_LAT) ? ans_fn(m_a, m_b) : ~ans_fn(m_a, m_b);
    assign fpa_except = (m_age == FPA_LAT) ? exc_fn(m_a, m_b) : ~exc_fn(m_a, m_b);

    // Reference model state
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_acc, n_started, n_hs;
    int          last_hs_cyc, start_cyc;
    logic [11:0] exp_q[$];
    logic [15:0] iss_q[$];
    int          acc_cyc_q[$];
    logic        prev_start, prev_valid;
    logic [7:0]  prev_ans;
    logic [3:0]  prev_exc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        iss_q.delete();
        acc_cyc_q.delete();
        n_acc = 0;
        n_started = 0;
        n_hs = 0;
        last_hs_cyc = cyc;
        start_cyc = cyc;
        prev_start = 1'b0;
        prev_valid = 1'b0;
        prev_ans = 8'h00;
        prev_exc = 4'h0;
`ifdef FPA_ISSUE_STATS_EN
        m_ops = 0;
        m_exc = 0;
`endif
    endtask

    // One clock: record handshakes at the coming edge, then check after it
    task automatic tick();
        logic [11:0] e;
        logic [15:0] p;
        int          ac;
        int          exp_st;
        if (in_valid && in_ready) begin
            exp_q.push_back({ans_fn(in_a, in_b), exc_fn(in_a, in_b)});
            iss_q.push_back({in_a, in_b});
            acc_cyc_q.push_back(cyc + 1);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            check("out_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_ans", 32'(out_ans), 32'(e[11:4]));
                check("out_except", 32'(out_except), 32'(e[3:0]));
`ifdef FPA_ISSUE_STATS_EN
                m_ops++;
                if (e[3:0] != 4'h0) m_exc++;
`endif
            end
            n_hs++;
            last_hs_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fpa_start && !prev_start) begin
            check("start_serial", 32'(n_started == n_hs), 32'd1);
            check("start_has_data", 32'(iss_q.size() > 0), 32'd1);
            if (iss_q.size() > 0) begin
                p  = iss_q.pop_front();
                ac = acc_cyc_q.pop_front();
                check("fpa_a", 32'(fpa_a), 32'(p[15:8]));
                check("fpa_b", 32'(fpa_b), 32'(p[7:0]));
                exp_st = imax(last_hs_cyc, ac) + 1;
                check("start_cycle", 32'(cyc), 32'(exp_st));
            end
            start_cyc = cyc;
            n_started++;
        end else if (n_started == n_hs && iss_q.size() > 0) begin
            exp_st = imax(last_hs_cyc, acc_cyc_q[0]) + 1;
            check("start_not_late", 32'(cyc < exp_st), 32'd1);
        end
        if (!fpa_start && prev_start) begin
            check("start_width", 32'(cyc - start_cyc), 32'(START_W));
        end
        if (out_valid && !prev_valid) begin
            check("valid_owner", 32'(n_started), 32'(n_hs + 1));
            check("latency", 32'(cyc - start_cyc), 32'(FPA_LAT));
        end
        if (prev_valid && last_hs_cyc != cyc) begin
            check("valid_hold", 32'(out_valid), 32'd1);
            check("ans_hold", 32'(out_ans), 32'(prev_ans));
            check("exc_hold", 32'(out_except), 32'(prev_exc));
        end
        if (prev_valid && last_hs_cyc == cyc) begin
            check("valid_drop", 32'(out_valid), 32'd0);
        end
        check("in_ready", 32'(in_ready), 32'((n_acc - n_started) < DEPTH));
`ifdef FPA_ISSUE_STATS_EN
        check("stat_ops", 32'(stat_ops), 32'(m_ops));
        check("stat_exc", 32'(stat_exc), 32'(m_exc));
`endif
        prev_start = fpa_start;
        prev_valid = out_valid;
        prev_ans   = out_ans;
        prev_exc   = out_except;
    endtask

    task automatic push_pair(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 200 && !got; i++) begin
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !out_valid; i++) begin
            tick();
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 500 && (n_hs != n_acc || out_valid); i++) begin
            tick();
        end
        check(tag, 32'(n_hs), 32'(n_acc));
    endtask

    // Assert clr between edges and check the asynchronous clear
    task automatic mid_clr(input string tag);
        #2;
        clr = 1'b1;
        #1;
        check({tag, "_start"}, 32'(fpa_start), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_fpa_a"}, 32'(fpa_a), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        check({tag, "_valid_held"}, 32'(out_valid), 32'd0);
        clr = 1'b0;
        in_valid = 1'b0;
        model_reset();
    endtask

    int accepted;
    int st0;
    int hs0;
    int push_cyc;
    logic got_now;
`ifdef FPA_ISSUE_STATS_EN
    int s_exc;
    int s_ops;
`endif

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_start", 32'(fpa_start), 32'd0);
        check("rst_fpa_a", 32'(fpa_a), 32'd0);
        check("rst_fpa_b", 32'(fpa_b), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ans", 32'(out_ans), 32'd0);
        check("rst_exc", 32'(out_except), 32'd0);
        clr = 1'b0;
        model_reset();
        tick();

        // Single operation, fixed values
        out_ready = 1'b1;
        push_pair("t1_push", 8'h98, 8'h13);
        push_cyc = cyc;
        wait_valid("t1_valid", 30);
        check("t1_latency", 32'(cyc - push_cyc), 32'(FPA_LAT + 1));
        check("t1_ans", 32'(out_ans), 32'h55);
        check("t1_exc", 32'(out_except), 32'h0);
        drain("t1_drain");

        // Back-to-back pushes with the output blocked
        out_ready = 1'b0;
        st0 = n_started;
        accepted = 0;
        in_valid = 1'b1;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            got_now = in_ready;
            tick();
            if (got_now) begin
                accepted++;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
        end
        check("t2_accepted", 32'(accepted), 32'(DEPTH + 1));
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        repeat (20) tick();
        check("t2_single_issue", 32'(n_started - st0), 32'd1);

        // Release the output: stalled pair enters, all results drain in order
        out_ready = 1'b1;
        got_now = 1'b0;
        for (int i = 0; i < 200 && !got_now; i++) begin
            got_now = in_ready;
            tick();
        end
        check("t3_stalled_push", 32'(got_now), 32'd1);
        drain("t3_drain");
        check("t3_in_ready", 32'(in_ready), 32'd1);

        // Exception flags captured and held until the handshake
        out_ready = 1'b0;
        push_pair("t4_push", 8'h78, 8'h01);
        wait_valid("t4_valid", 30);
        check("t4_exc", 32'(out_except), 32'h4);
        repeat (5) tick();
        check("t4_exc_held", 32'(out_except), 32'h4);
`ifdef FPA_ISSUE_STATS_EN
        s_exc = stat_exc;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
`ifdef FPA_ISSUE_STATS_EN
        check("t4_stat_exc", 32'(stat_exc - s_exc), 32'd1);
`endif

        // clr while waiting on the adder with two pairs queued
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        mid_clr("t5_wait_clr");
        repeat (15) tick();
        check("t5_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push_pair("t5_push", 8'h3C, 8'hA5);
        drain("t5_drain");

        // clr while the start pulse is high
        push_pair("t5b_push", 8'h11, 8'h22);
        tick();
        mid_clr("t5b_issue_clr");
        repeat (3) tick();

        // Long output stall then a one-cycle ready pulse
        out_ready = 1'b0;
        push_pair("t6_push", 8'hC7, 8'h5E);
        wait_valid("t6_valid", 30);
        repeat (10) tick();
        hs0 = n_hs;
`ifdef FPA_ISSUE_STATS_EN
        s_ops = stat_ops;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("t6_one_hs", 32'(n_hs - hs0), 32'd1);
        check("t6_valid_low", 32'(out_valid), 32'd0);
`ifdef FPA_ISSUE_STATS_EN
        check("t6_stat_ops", 32'(stat_ops - s_ops), 32'd1);
`endif

        // Randomized traffic: mostly blocked output first, then mostly open
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            if (i < 200) begin
                out_ready = ($urandom_range(0, 3) == 0);
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        drain("rand_drain");
        repeat (2) tick();
        check("final_in_ready", 32'(in_ready), 32'd1);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
